shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
- Sequential unsigned multiplier for WIDTH x WIDTH operands, producing a 2*WIDTH product.
- Uses the radix-2 shift-and-add algorithm. Each iteration does one WIDTH-bit add with carry-out, which is the same operation our ripple-carry adder provides.
- Sits directly downstream of the adder datapath and consumes its sum and carry-out every iteration.
- Exposes a start/busy/done handshake to the control logic above it.

Parameters:
- WIDTH, 4, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  single system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request to begin a multiply; sampled only when busy=0
- multiplicand  input  WIDTH  operand M; captured on an accepted start
- multiplier  input  WIDTH  operand Q; captured on an accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse when product is updated
- product  output  2*WIDTH  result of the most recent completed operation

Behaviour:
- Reset (rst_n=0, takes effect immediately, no clock needed):
  - state=IDLE; busy=0, done=0, product=0.
  - Internal registers cleared: A, Q, M, carry C, count.
- Internal registers:
  - A: WIDTH bits, accumulator high half.
  - Q: WIDTH bits, multiplier and low half.
  - M: WIDTH bits, multiplicand.
  - C: 1 bit, carry.
  - count: ceil(log2(WIDTH+1)) bits.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - If start=1 at an edge: A<=0, C<=0, Q<=multiplier, M<=multiplicand, count<=0, go to RUN.
  - If start=0: stay in IDLE.
- RUN (busy=1): one iteration per edge.
  - If Q[0]=1: {C,A} <= A+M, full WIDTH+1-bit sum; the carry must be kept.
  - If Q[0]=0: {C,A} <= {0,A}.
  - In the same edge, shift {C,A,Q} right one bit, so that A<={sum_C, sum_A[WIDTH-1:1]} and Q<={sum_A[0], Q[WIDTH-1:1]}.
  - count increments. After the WIDTH-th iteration (count reaches WIDTH-1 before the edge), go to DONE.
- DONE (busy=1):
  - Next edge: product<={A,Q}, done<=1, busy<=0, go to IDLE.
  - done deasserts on the following edge, so it is exactly one cycle wide.
- Latency and throughput:
  - start sampled at edge E0; iterations on E1..EWIDTH; product and done update at E(WIDTH+1).
  - For WIDTH=4: done is high in the cycle after the 5th edge following start.
  - Throughput is one operation per WIDTH+2 cycles.
- Handshake rules:
  - start while busy=1 is ignored; operands are not re-captured and the running operation is unaffected.
  - start while done=1 is legal (state is IDLE) and is accepted; this allows back-to-back operations with no gap.
  - Operand inputs need only be stable at the accepting edge.
- Output holding:
  - product holds its value between completions. It changes only at the done edge or on reset.
  - product never shows intermediate values.
- Arithmetic and boundary conditions:
  - Unsigned only; no overflow is possible, since max (2^WIDTH-1)^2 fits in 2*WIDTH bits.
  - All-ones operands exercise the carry every iteration.
  - Zero operands still take the full WIDTH+2 cycles; there is no early termination.
- Reset mid-operation: aborts immediately to the IDLE reset values. product=0; no done pulse is produced.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Reset: assert rst_n=0 asynchronously mid-cycle -> busy=0, done=0, product=0x00 immediately, before the next clk edge.
- Carry path: WIDTH=4, M=0xF, Q=0xF, start for 1 cycle -> busy=1 for 5 cycles; done pulses once at edge 5; product=0xE1 (225); product holds after done drops.
- Zero and mixed operands: 0x0*0x9 -> product=0x00 after 5 edges. 0xB*0x6 -> product=0x42. 0x1*0xF -> product=0x0F.
- Busy lockout: start 0x3*0x5, then pulse start with 0xF*0xF while busy=1 -> product=0x0F; exactly one done pulse; no second operation begins.
- Back-to-back and reset abort:
  - Assert start with 0x7*0x7 in the done cycle of a prior 0x2*0x3 -> product=0x06, then 0x31 exactly 6 cycles later.
  - Separately, drop rst_n during RUN -> product=0x00, no done pulse, and the next start completes normally.
- Exhaustive: all 256 operand pairs for WIDTH=4, issued back-to-back -> each product equals M*Q, one done per operation, 6-cycle spacing.

Source files
------------

// File: rtl/shift_add_multiplier_if.sv
// Handshake and operand/result bundle between the control logic and the shift-add multiplier.
interface shift_add_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-and-add unsigned multiplier: one WIDTH-bit add with carry-out per clock,
// WIDTH iterations, then a single registered completion cycle.
module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    shift_add_multiplier_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   m;
    logic [CW-1:0]      count;
    logic [WIDTH:0]     sum;
    logic               last_iter;
    logic               done_r;
    logic [2*WIDTH-1:0] product_r;

    assign last_iter = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = RUN;
            RUN:     if (last_iter) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // sum[WIDTH] is the carry C; it is consumed by the same-edge shift, so it never needs its own flop.
    always_comb begin
        sum = {1'b0, a} + (q[0] ? {1'b0, m} : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a         <= '0;
            q         <= '0;
            m         <= '0;
            count     <= '0;
            done_r    <= 1'b0;
            product_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a     <= '0;
                        q     <= bus.multiplier;
                        m     <= bus.multiplicand;
                        count <= '0;
                    end
                end
                RUN: begin
                    a     <= sum[WIDTH:1];
                    q     <= {sum[0], q[WIDTH-1:1]};
                    count <= count + 1'b1;
                end
                DONE: begin
                    product_r <= {a, q};
                    done_r    <= 1'b1;
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.done    = done_r;
    assign bus.product = product_r;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench: cycle-accurate expectations from the latency rules, products from plain M*Q.
module tb_shift_add_multiplier;
    localparam int WIDTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [2*WIDTH-1:0] expProduct;

    always #5 clk = ~clk;

    shift_add_multiplier_if #(.WIDTH(WIDTH)) bus ();

    shift_add_multiplier #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            checkOutput("idle_busy", 32'(bus.busy), 32'd0);
            checkOutput("idle_done", 32'(bus.done), 32'd0);
            checkOutput("idle_hold", 32'(bus.product), 32'(expProduct));
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle so a following call is back-to-back.
    task automatic applyStimulus(input logic [WIDTH-1:0] mVal, input logic [WIDTH-1:0] qVal,
                                 input bit lockout);
        bus.start        = 1'b1;
        bus.multiplicand = mVal;
        bus.multiplier   = qVal;
        @(posedge clk);
        for (int k = 0; k < WIDTH + 1; k++) begin
            @(negedge clk);
            bus.start        = lockout && (k == 2);
            bus.multiplicand = lockout ? {WIDTH{1'b1}} : WIDTH'($urandom);
            bus.multiplier   = lockout ? {WIDTH{1'b1}} : WIDTH'($urandom);
            checkOutput("run_busy", 32'(bus.busy), 32'd1);
            checkOutput("run_done", 32'(bus.done), 32'd0);
            checkOutput("run_hold", 32'(bus.product), 32'(expProduct));
        end
        @(negedge clk);
        bus.start  = 1'b0;
        expProduct = (2*WIDTH)'(mVal) * (2*WIDTH)'(qVal);
        checkOutput("done_pulse", 32'(bus.done), 32'd1);
        checkOutput("done_busy", 32'(bus.busy), 32'd0);
        checkOutput("product", 32'(bus.product), 32'(expProduct));
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;
        expProduct       = '0;
        #2;
        checkOutput("reset_busy", 32'(bus.busy), 32'd0);
        checkOutput("reset_done", 32'(bus.done), 32'd0);
        checkOutput("reset_product", 32'(bus.product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(2);

        applyStimulus(4'hF, 4'hF, 1'b0);
        idleCycles(2);

        applyStimulus(4'h0, 4'h9, 1'b0);
        applyStimulus(4'hB, 4'h6, 1'b0);
        applyStimulus(4'h1, 4'hF, 1'b0);
        idleCycles(1);

        applyStimulus(4'h3, 4'h5, 1'b1);
        idleCycles(3);

        applyStimulus(4'h2, 4'h3, 1'b0);
        applyStimulus(4'h7, 4'h7, 1'b0);
        idleCycles(1);

        bus.start        = 1'b1;
        bus.multiplicand = 4'hA;
        bus.multiplier   = 4'hB;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        expProduct = '0;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_product", 32'(bus.product), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycles(6);
        applyStimulus(4'hC, 4'hD, 1'b0);

        for (int r = 0; r < 40; r++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'b0);
            if ($urandom_range(0, 1) == 1) idleCycles(int'($urandom_range(1, 3)));
        end

        for (int i = 0; i < 256; i++) begin
            applyStimulus(WIDTH'(i >> 4), WIDTH'(i & 15), 1'b0);
        end
        idleCycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
